apb_timer_nch: RTL and testbench
================================

# apb_timer_nch

Parametrised APB down-counting timer bank: successor to the fixed two-channel timer subsystem. Provides NUM_CH independent channels of CNT_W bits, each with free-running/user-defined reload, a new one-shot mode, per-channel interrupt masking, and ETB start/stop and timeout-trigger hooks. Sits on the peripheral APB bus, clocked from `pclk`, with interrupts routed to the interrupt controller and triggers routed to the ETB.

## Interface
- `NUM_CH`, default 2: number of channels; legal range 1..8.
- `CNT_W`, default 32: counter and load width; legal range 8..32.

Ports (all synchronous to `pclk`):
- `pclk` in 1: single clock for APB and counters.
- `presetn` in 1: asynchronous active-low reset.
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `pwrite` in 1: APB write.
- `paddr` in 8: byte address; bits [1:0] ignored.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `etb_trig_en_on` in NUM_CH: one-cycle pulse per channel; sets the channel enable.
- `etb_trig_en_off` in NUM_CH: one-cycle pulse per channel; clears the channel enable.
- `etb_trig` out NUM_CH: one-cycle timeout pulse per channel.
- `intr` out NUM_CH: per-channel level interrupt (raw AND NOT mask).
- `intr_any` out 1: OR of `intr`.

## Operation
Per-channel registers, base = 0x14·ch:
- +0x00 LOAD (RW): CNT_W bits.
- +0x04 CUR (RO): current count.
- +0x08 CTRL (RW): bit0 EN, bit1 MODE (0 free-running, 1 user-defined), bit2 MASK, bit3 ONESHOT.
- +0x0C EOI (RO): read returns 0 and clears that channel's raw interrupt.
- +0x10 ISTAT (RO): bit0 masked status.

Global registers:
- 0xA0 ALL_ISTAT: masked status, bits [NUM_CH-1:0].
- 0xA4 ALL_EOI: read returns 0 and clears all raw interrupts.
- 0xA8 ALL_RAW: raw status.

Unmapped addresses and channels ≥ NUM_CH read 0; writes to them are ignored. Read bits above CNT_W or NUM_CH are 0. Writes are truncated to CNT_W.

Channel behaviour:
- **Enable rising edge** (0→1 from any source): counter loads LOAD.
- **Counting:** while EN=1, the counter decrements by 1 every `pclk`.
- **Timeout:** CUR==0 with EN=1 defines a timeout. On the next edge:
  - raw interrupt is set;
  - `etb_trig` pulses high for that one cycle (independent of MASK);
  - counter reloads LOAD if MODE=1, or all-ones (CNT_W) if MODE=0.
- **One-shot:** with ONESHOT=1, a timeout clears EN instead of reloading; CUR holds at 0.
- **Disable:** EN=0 freezes CUR at its last value.
- **LOAD while running:** a write to LOAD with EN=1 takes effect at the next reload only.
- **LOAD = 0:** timeout fires every cycle; `etb_trig` stays high continuously.

Priorities:
- **EN sources:** APB CTRL write > `etb_trig_en_off` > `etb_trig_en_on`. On and off asserted together → off wins.
- **Raw interrupt:** a timeout set in the same cycle as an EOI/ALL_EOI read clear → set wins.

## Timing
- **APB:** zero wait states. `prdata` is combinational from `paddr` when psel & ~pwrite; otherwise 0.
- **Writes:** take effect at the edge where psel & penable & pwrite.
- **EOI clears:** take effect at the edge where psel & penable & ~pwrite.
- **Enable latency:** enable at edge N → CUR=LOAD after N, LOAD-1 after N+1, 0 after N+LOAD. Raw interrupt and `etb_trig` are high after edge N+LOAD+1. Period is LOAD+1 cycles.
- **Interrupt path:** `intr` and `intr_any` are combinational from registered raw and MASK; no extra latency.
- **Reset values:** LOAD=0, CUR=0, CTRL=0, raw=0, `etb_trig`=0, `intr`=0, `intr_any`=0, `prdata`=0.
- **Reset mid-count:** aborts immediately, with no trigger pulse.

## Structure
- **Package `timer_pkg`:**
  - register offsets (LOAD/CUR/CTRL/EOI/ISTAT, stride 0x14, global 0xA0/0xA4/0xA8);
  - CTRL bit indices;
  - NUM_CH/CNT_W legality limits.
- **Sub-module `timer_channel`:**
  - holds LOAD/CTRL/counter/raw;
  - inputs: decoded write strobes, clear strobe, ETB on/off;
  - outputs: CUR, raw, `etb_trig`.
- **Top level:** instantiates `timer_channel` NUM_CH times via generate; does APB decode and the read mux.

## Test plan
1. LOAD=5, CTRL=0x3 → CUR reads 5,4,…,0,5; `etb_trig` pulses every 6 cycles; `intr[0]`=1 until EOI read, then 0 next cycle.
2. MODE=0, CNT_W=8, CTRL=0x1 → count reaches 0, then CUR=0xFF; raw set.
3. ONESHOT: LOAD=3, CTRL=0xB → single timeout; CTRL reads 0xA afterwards; CUR holds 0; no second `etb_trig`.
4. MASK=1 → ALL_RAW bit=1, ISTAT=0, `intr`=0, `etb_trig` still pulses; ALL_EOI read clears all raw bits.
5. Same-cycle conflicts:
   - `etb_trig_en_on` with `etb_trig_en_off` → EN stays 0;
   - `etb_trig_en_on` with an APB CTRL write of 0 → EN=0;
   - timeout with EOI read → raw remains 1.
6. NUM_CH=8: channel 7 at 0x8C..0x9C works; `presetn` low mid-count → all outputs 0 and CUR=0 asynchronously.

Source files
------------

// File: rtl/apb_timer_nch_pkg.sv
// Shared register map, CTRL bit layout and parameter limits for the APB timer bank.
package timer_pkg;

  localparam int unsigned NUM_CH_MIN = 1;
  localparam int unsigned NUM_CH_MAX = 8;
  localparam int unsigned CNT_W_MIN  = 8;
  localparam int unsigned CNT_W_MAX  = 32;

  localparam logic [7:0] OFS_LOAD      = 8'h00;
  localparam logic [7:0] OFS_CUR       = 8'h04;
  localparam logic [7:0] OFS_CTRL      = 8'h08;
  localparam logic [7:0] OFS_EOI       = 8'h0C;
  localparam logic [7:0] OFS_ISTAT     = 8'h10;
  localparam logic [7:0] CH_STRIDE     = 8'h14;
  localparam logic [7:0] REG_ALL_ISTAT = 8'hA0;
  localparam logic [7:0] REG_ALL_EOI   = 8'hA4;
  localparam logic [7:0] REG_ALL_RAW   = 8'hA8;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE    = 1;
  localparam int unsigned CTRL_MASK    = 2;
  localparam int unsigned CTRL_ONESHOT = 3;
  localparam int unsigned CTRL_BITS    = 4;

  function automatic logic [7:0] reg_addr(input int unsigned ch, input logic [7:0] ofs);
    return 8'(ch * CH_STRIDE) + ofs;
  endfunction

endpackage

// File: rtl/apb_timer_nch_if.sv
// Zero-wait-state APB bus bundle for the timer bank.
interface apb_timer_nch_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_timer_nch_channel.sv
// One down-counting timer channel: LOAD/CTRL registers, counter, raw interrupt and ETB trigger.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_load,
  input  logic                 wr_ctrl,
  input  logic [CNT_W-1:0]     wdata,
  input  logic                 clr,
  input  logic                 en_on,
  input  logic                 en_off,
  output logic [CNT_W-1:0]     load,
  output logic [CNT_W-1:0]     cur,
  output logic [CTRL_BITS-1:0] ctrl,
  output logic                 raw,
  output logic                 trig
);

  logic en;
  logic en_next;
  logic timeout;

  assign en      = ctrl[CTRL_EN];
  assign timeout = en && (cur == '0);

  // APB write beats ETB off, which beats ETB on; a one-shot expiry only clears EN when nothing else drives it.
  always_comb begin
    en_next = en;
    if (wr_ctrl)                            en_next = wdata[CTRL_EN];
    else if (en_off)                        en_next = 1'b0;
    else if (en_on)                         en_next = 1'b1;
    else if (timeout && ctrl[CTRL_ONESHOT]) en_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load <= '0;
      cur  <= '0;
      ctrl <= '0;
      raw  <= 1'b0;
      trig <= 1'b0;
    end else begin
      if (wr_load) load <= wdata;

      if (wr_ctrl) ctrl <= {wdata[CTRL_BITS-1:1], en_next};
      else         ctrl[CTRL_EN] <= en_next;

      if (en_next && !en) begin
        cur <= load;
      end else if (timeout) begin
        if (!ctrl[CTRL_ONESHOT]) cur <= ctrl[CTRL_MODE] ? load : '1;
      end else if (en) begin
        cur <= cur - CNT_W'(1);
      end

      trig <= timeout;

      if (timeout)  raw <= 1'b1;
      else if (clr) raw <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_timer_nch.sv
// APB timer bank top: address decode, read mux and NUM_CH timer_channel instances.
module apb_timer_nch
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  apb_timer_nch_if.slave    apb,
  input  logic [NUM_CH-1:0] etb_trig_en_on,
  input  logic [NUM_CH-1:0] etb_trig_en_off,
  output logic [NUM_CH-1:0] etb_trig,
  output logic [NUM_CH-1:0] intr,
  output logic              intr_any
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
    $error("apb_timer_nch: NUM_CH or CNT_W out of range");
  end

  logic              wr_acc;
  logic              rd_acc;
  logic              rd_sel;
  logic              all_eoi;
  logic [7:0]        addr;
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] mask;
  logic [CNT_W-1:0]  load_q [NUM_CH];
  logic [CNT_W-1:0]  cur_q  [NUM_CH];
  logic [CTRL_BITS-1:0] ctrl_q [NUM_CH];
  logic [31:0]       prdata_c;
  logic              unused_bits;

  assign wr_acc      = apb.psel & apb.penable & apb.pwrite;
  assign rd_acc      = apb.psel & apb.penable & ~apb.pwrite;
  assign rd_sel      = apb.psel & ~apb.pwrite;
  assign addr        = {apb.paddr[7:2], 2'b00};
  assign all_eoi     = rd_acc && (addr == REG_ALL_EOI);
  assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_channel (
      .clk     (pclk),
      .rst_n   (presetn),
      .wr_load (wr_acc && (addr == reg_addr(ch, OFS_LOAD))),
      .wr_ctrl (wr_acc && (addr == reg_addr(ch, OFS_CTRL))),
      .wdata   (apb.pwdata[CNT_W-1:0]),
      .clr     (all_eoi || (rd_acc && (addr == reg_addr(ch, OFS_EOI)))),
      .en_on   (etb_trig_en_on[ch]),
      .en_off  (etb_trig_en_off[ch]),
      .load    (load_q[ch]),
      .cur     (cur_q[ch]),
      .ctrl    (ctrl_q[ch]),
      .raw     (raw[ch]),
      .trig    (etb_trig[ch])
    );
    assign mask[ch] = ctrl_q[ch][CTRL_MASK];
  end

  assign intr     = raw & ~mask;
  assign intr_any = |intr;

  always_comb begin
    prdata_c = '0;
    if (rd_sel) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (addr == reg_addr(ch, OFS_LOAD))  prdata_c[CNT_W-1:0]     = load_q[ch];
        if (addr == reg_addr(ch, OFS_CUR))   prdata_c[CNT_W-1:0]     = cur_q[ch];
        if (addr == reg_addr(ch, OFS_CTRL))  prdata_c[CTRL_BITS-1:0] = ctrl_q[ch];
        if (addr == reg_addr(ch, OFS_ISTAT)) prdata_c[0]             = intr[ch];
      end
      if (addr == REG_ALL_ISTAT) prdata_c[NUM_CH-1:0] = intr;
      if (addr == REG_ALL_RAW)   prdata_c[NUM_CH-1:0] = raw;
    end
  end

  assign apb.prdata = prdata_c;

endmodule

// File: tb/tb_apb_timer_nch.sv
// Scoreboard bench for apb_timer_nch with eight 8-bit channels.
module tb_apb_timer_nch;

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = 8;

  typedef struct packed {
    logic [31:0] cur;
    logic        trig;
    logic        irq;
  } exp_t;

  logic           pclk = 1'b0;
  logic           presetn = 1'b0;
  logic [NCH-1:0] en_on;
  logic [NCH-1:0] en_off;
  logic [NCH-1:0] etb_trig;
  logic [NCH-1:0] intr;
  logic           intr_any;

  exp_t        sb[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;

  apb_timer_nch_if apb ();

  apb_timer_nch #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .apb             (apb),
    .etb_trig_en_on  (en_on),
    .etb_trig_en_off (en_off),
    .etb_trig        (etb_trig),
    .intr            (intr),
    .intr_any        (intr_any)
  );

  always #5 pclk = ~pclk;

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwdata = d;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    @(posedge pclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = a;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    #1 d = apb.prdata;
    @(posedge pclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // Setup-phase-only read: prdata is visible without an access, so no EOI side effect.
  task automatic peek(input logic [7:0] a);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
  endtask

  task automatic test_reset();
    logic [7:0]  ra [6] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'hA0, 8'hA8};
    logic [31:0] x;
    for (int i = 0; i < 6; i++) rd_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      peek(ra[i]); #1;
      x = rd_q.pop_front();
      checks++;
      if (apb.prdata !== x) begin
        errors++; $display("FAIL reset_reg addr=%h: got %h expected %h", ra[i], apb.prdata, x);
      end
    end
    checks++;
    if ({etb_trig, intr, intr_any} !== '0) begin
      errors++; $display("FAIL reset_outputs: got trig=%h intr=%h any=%b expected all 0", etb_trig, intr, intr_any);
    end
  endtask

  task automatic test_count();
    logic [31:0] m_cur, d, x;
    logic        m_trig, m_irq, to;
    exp_t        e;
    logic [7:0]  ra [4] = '{8'h04, 8'h10, 8'h0C, 8'h08};
    apb_write(8'h00, 32'd5);
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = 8'h00; #1;
    checks++;
    if (apb.prdata !== 32'h0) begin
      errors++; $display("FAIL prdata_on_write: got %h expected 0", apb.prdata);
    end
    apb_write(8'h08, 32'h3);
    m_cur = 5; m_trig = 1'b0; m_irq = 1'b0;
    peek(8'h04);
    for (int k = 0; k < 14; k++) begin
      e.cur = m_cur; e.trig = m_trig; e.irq = m_irq;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({apb.prdata, etb_trig[0], intr[0]} !== {e.cur, e.trig, e.irq}) begin
        errors++;
        $display("FAIL count_ch0 k=%0d: got cur=%0d trig=%b intr=%b expected cur=%0d trig=%b intr=%b",
                 k, apb.prdata, etb_trig[0], intr[0], e.cur, e.trig, e.irq);
      end
      @(posedge pclk); #1;
      to = (m_cur == 0); m_trig = to;
      if (to) begin m_irq = 1'b1; m_cur = 5; end else m_cur = m_cur - 1;
    end
    // Counter keeps running through the three edges of the disabling write.
    for (int j = 0; j < 3; j++) m_cur = (m_cur == 0) ? 32'd5 : m_cur - 1;
    apb_write(8'h08, 32'h2);
    rd_q.push_back(m_cur); rd_q.push_back(32'h1); rd_q.push_back(32'h0); rd_q.push_back(32'h2);
    for (int i = 0; i < 4; i++) begin
      apb_read(ra[i], d);
      x = rd_q.pop_front();
      checks++;
      if (d !== x) begin
        errors++; $display("FAIL count_regs addr=%h: got %h expected %h", ra[i], d, x);
      end
    end
    checks++;
    if ({intr[0], intr_any} !== 2'b00) begin
      errors++; $display("FAIL eoi_clear: got intr0=%b any=%b expected 0 0", intr[0], intr_any);
    end
  endtask

  task automatic test_mode0();
    logic [31:0] m_cur, d, x;
    logic        m_trig, m_irq, to;
    exp_t        e;
    logic [7:0]  ra [6] = '{8'h14, 8'h18, 8'h1C, 8'hA8, 8'hAC, 8'hFC};
    apb_write(8'h14, 32'd2);
    apb_write(8'h1C, 32'h1);
    m_cur = 2; m_trig = 1'b0; m_irq = 1'b0;
    peek(8'h18);
    for (int k = 0; k < 5; k++) begin
      e.cur = m_cur; e.trig = m_trig; e.irq = m_irq;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({apb.prdata, etb_trig[1], intr[1]} !== {e.cur, e.trig, e.irq}) begin
        errors++;
        $display("FAIL mode0_ch1 k=%0d: got cur=%h trig=%b intr=%b expected cur=%h trig=%b intr=%b",
                 k, apb.prdata, etb_trig[1], intr[1], e.cur, e.trig, e.irq);
      end
      @(posedge pclk); #1;
      to = (m_cur == 0); m_trig = to;
      if (to) begin m_irq = 1'b1; m_cur = 32'hFF; end else m_cur = m_cur - 1;
    end
    for (int j = 0; j < 3; j++) m_cur = (m_cur == 0) ? 32'hFF : m_cur - 1;
    apb_write(8'h1C, 32'h0);
    apb_write(8'h14, 32'h1FF);
    rd_q.push_back(32'hFF); rd_q.push_back(m_cur); rd_q.push_back(32'h0);
    rd_q.push_back(32'h2); rd_q.push_back(32'h0); rd_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      apb_read(ra[i], d);
      x = rd_q.pop_front();
      checks++;
      if (d !== x) begin
        errors++; $display("FAIL mode0_regs addr=%h: got %h expected %h", ra[i], d, x);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] m_cur, d, x;
    logic        m_en, m_trig, m_irq, to;
    exp_t        e;
    logic [7:0]  ra [3] = '{8'h30, 8'h2C, 8'h38};
    apb_write(8'h28, 32'd3);
    apb_write(8'h30, 32'hB);
    m_cur = 3; m_en = 1'b1; m_trig = 1'b0; m_irq = 1'b0;
    peek(8'h2C);
    for (int k = 0; k < 8; k++) begin
      e.cur = m_cur; e.trig = m_trig; e.irq = m_irq;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({apb.prdata, etb_trig[2], intr[2]} !== {e.cur, e.trig, e.irq}) begin
        errors++;
        $display("FAIL oneshot_ch2 k=%0d: got cur=%0d trig=%b intr=%b expected cur=%0d trig=%b intr=%b",
                 k, apb.prdata, etb_trig[2], intr[2], e.cur, e.trig, e.irq);
      end
      @(posedge pclk); #1;
      to = m_en && (m_cur == 0); m_trig = to;
      if (to) begin m_irq = 1'b1; m_en = 1'b0; end
      else if (m_en) m_cur = m_cur - 1;
    end
    rd_q.push_back(32'hA); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
    for (int i = 0; i < 3; i++) begin
      apb_read(ra[i], d);
      x = rd_q.pop_front();
      checks++;
      if (d !== x) begin
        errors++; $display("FAIL oneshot_regs addr=%h: got %h expected %h", ra[i], d, x);
      end
    end
  endtask

  task automatic test_mask();
    logic [31:0] m_cur, d, x;
    logic        m_trig, to;
    exp_t        e;
    logic [7:0]  ra [5] = '{8'hA8, 8'h4C, 8'hA0, 8'hA4, 8'hA8};
    apb_write(8'h3C, 32'd1);
    apb_write(8'h44, 32'h7);
    m_cur = 1; m_trig = 1'b0;
    peek(8'h40);
    for (int k = 0; k < 6; k++) begin
      e.cur = m_cur; e.trig = m_trig; e.irq = 1'b0;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({apb.prdata, etb_trig[3], intr[3]} !== {e.cur, e.trig, e.irq}) begin
        errors++;
        $display("FAIL mask_ch3 k=%0d: got cur=%0d trig=%b intr=%b expected cur=%0d trig=%b intr=%b",
                 k, apb.prdata, etb_trig[3], intr[3], e.cur, e.trig, e.irq);
      end
      @(posedge pclk); #1;
      to = (m_cur == 0); m_trig = to;
      m_cur = to ? 32'd1 : m_cur - 1;
    end
    apb_write(8'h44, 32'h6);
    checks++;
    if ({intr, intr_any} !== {8'h06, 1'b1}) begin
      errors++; $display("FAIL mask_intr: got intr=%h any=%b expected intr=06 any=1", intr, intr_any);
    end
    rd_q.push_back(32'h0E); rd_q.push_back(32'h0); rd_q.push_back(32'h06);
    rd_q.push_back(32'h0); rd_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      apb_read(ra[i], d);
      x = rd_q.pop_front();
      checks++;
      if (d !== x) begin
        errors++; $display("FAIL mask_regs step=%0d addr=%h: got %h expected %h", i, ra[i], d, x);
      end
    end
    checks++;
    if (intr_any !== 1'b0) begin
      errors++; $display("FAIL all_eoi_any: got %b expected 0", intr_any);
    end
  endtask

  task automatic test_conflicts();
    logic [31:0] d, x;
    logic [1:0]  mode;
    apb_write(8'h50, 32'd10);
    // mode 0: on+off, 1: on alone, 2: off alone, 3: on with CTRL write of 0
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      rd_q.push_back((mode == 2'd1) ? 32'h1 : 32'h0);
      if (mode == 2'd3) begin
        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = 8'h58; apb.pwdata = 32'h0;
        @(posedge pclk); #1;
        apb.penable = 1'b1; en_on[4] = 1'b1;
        @(posedge pclk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; en_on[4] = 1'b0;
      end else begin
        @(posedge pclk); #1;
        en_on[4]  = (mode != 2'd2);
        en_off[4] = (mode != 2'd1);
        @(posedge pclk); #1;
        en_on[4] = 1'b0; en_off[4] = 1'b0;
      end
      apb_read(8'h58, d);
      x = rd_q.pop_front();
      checks++;
      if (d !== x) begin
        errors++; $display("FAIL en_priority mode=%0d: got ctrl=%h expected %h", m, d, x);
      end
    end
    // LOAD=0 on channel 5: timeout every cycle
    apb_write(8'h6C, 32'h3);
    @(posedge pclk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (etb_trig[5] !== 1'b1) begin
        errors++; $display("FAIL load0_trig k=%0d: got %b expected 1", k, etb_trig[5]);
      end
      @(posedge pclk); #1;
    end
    rd_q.push_back(32'h0); rd_q.push_back(32'h20);
    apb_read(8'h70, d);
    x = rd_q.pop_front();
    checks++;
    if (d !== x) begin
      errors++; $display("FAIL eoi_read_value: got %h expected %h", d, x);
    end
    peek(8'hA8); #1;
    x = rd_q.pop_front();
    checks++;
    if (apb.prdata !== x) begin
      errors++; $display("FAIL set_beats_clear: got raw=%h expected %h", apb.prdata, x);
    end
    apb_write(8'h6C, 32'h0);
    apb_read(8'h70, d);
    rd_q.push_back(32'h0);
    peek(8'hA8); #1;
    x = rd_q.pop_front();
    checks++;
    if (apb.prdata !== x) begin
      errors++; $display("FAIL eoi_after_stop: got raw=%h expected %h", apb.prdata, x);
    end
  endtask

  task automatic test_ch7_reset();
    logic [31:0] m_cur, x;
    logic        m_trig, m_irq, to;
    exp_t        e;
    logic [7:0]  ra [3] = '{8'h90, 8'h94, 8'h8C};
    apb_write(8'h8C, 32'd2);
    apb_write(8'h94, 32'h3);
    m_cur = 2; m_trig = 1'b0; m_irq = 1'b0;
    peek(8'h90);
    for (int k = 0; k < 6; k++) begin
      e.cur = m_cur; e.trig = m_trig; e.irq = m_irq;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if ({apb.prdata, etb_trig[7], intr[7]} !== {e.cur, e.trig, e.irq}) begin
        errors++;
        $display("FAIL ch7 k=%0d: got cur=%0d trig=%b intr=%b expected cur=%0d trig=%b intr=%b",
                 k, apb.prdata, etb_trig[7], intr[7], e.cur, e.trig, e.irq);
      end
      @(posedge pclk); #1;
      to = (m_cur == 0); m_trig = to;
      if (to) begin m_irq = 1'b1; m_cur = 2; end else m_cur = m_cur - 1;
    end
    e.cur = m_cur; e.trig = m_trig; e.irq = m_irq;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    checks++;
    if ({apb.prdata, etb_trig[7], intr_any} !== {e.cur, e.trig, e.irq}) begin
      errors++;
      $display("FAIL ch7_pre_reset: got cur=%0d trig=%b any=%b expected cur=%0d trig=%b any=%b",
               apb.prdata, etb_trig[7], intr_any, e.cur, e.trig, e.irq);
    end
    peek(8'h9C); #1;
    checks++;
    if (apb.prdata !== 32'h1) begin
      errors++; $display("FAIL ch7_istat: got %h expected 1", apb.prdata);
    end
    presetn = 1'b0; #1;
    checks++;
    if ({etb_trig, intr, intr_any} !== '0) begin
      errors++; $display("FAIL async_reset_outputs: got trig=%h intr=%h any=%b expected all 0", etb_trig, intr, intr_any);
    end
    for (int i = 0; i < 3; i++) rd_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      peek(ra[i]); #1;
      x = rd_q.pop_front();
      checks++;
      if (apb.prdata !== x) begin
        errors++; $display("FAIL async_reset_reg addr=%h: got %h expected %h", ra[i], apb.prdata, x);
      end
    end
    @(negedge pclk);
    presetn = 1'b1;
    apb.psel = 1'b0;
  endtask

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    en_on = '0; en_off = '0;
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    test_reset();
    test_count();
    test_mode0();
    test_oneshot();
    test_mask();
    test_conflicts();
    test_ch7_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
